// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated N-way selector.
//   arb_mode_e : arbitration policy (fixed priority or round-robin)
//   sel_width  : channel index width, never narrower than one bit
package mux_pkg;

   typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way request arbiter with an optional round-robin pointer.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : per-channel request vector
//   advance   : a grant was consumed this cycle; move the pointer past it
//   grant     : one-hot grant, zero when no request is present
//   grant_idx : binary index of the granted channel (0 when none)
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter arb_mode_e   ARB_MODE = ARB_RR,
   parameter int unsigned SEL_W    = sel_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx
);

   logic [SEL_W-1:0] ptr_q, ptr_d;

   // Two passes give a wrapped search without rotating the vector:
   // first channels at or above the pointer, then those below it.
   always_comb begin
      int unsigned base;
      logic        found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      base      = (ARB_MODE == ARB_RR) ? int'(ptr_q) : 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i] && (i >= base)) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = SEL_W'(i);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i] && (i < base)) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (ARB_MODE != ARB_RR) begin
         ptr_d = '0;
      end else if (advance) begin
         ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/rr_arb_mux.sv
// Arbitrated N-input selector with one registered output stage and
// valid/ready handshakes on every input and on the output.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : per-channel request
//   in_data   : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready  : one-hot (or zero) accept strobe
//   out_valid : output register holds an untaken item
//   out_data  : registered data
//   out_sel   : index of the channel that produced out_data
//   out_ready : downstream accepts
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned WIDTH    = 32,
   parameter arb_mode_e   ARB_MODE = ARB_RR,
   parameter int unsigned SEL_W    = sel_width(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   input  logic               out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;

   logic [N-1:0]     grant;
   logic [SEL_W-1:0] grant_idx;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] grant_data;

   assign load_en = !out_valid_q || out_ready;
   // Grant is only non-zero when some request is valid, so a non-zero
   // in_ready already implies a transfer.
   assign in_ready = (rst || !load_en) ? '0 : grant;
   assign xfer     = |in_ready;

   rr_arbiter #(
      .N        (N),
      .ARB_MODE (ARB_MODE),
      .SEL_W    (SEL_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // One-hot grant lets the data select be a plain OR of masked channels.
   always_comb begin
      grant_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant[i]) grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (load_en) begin
         out_valid_d = xfer;
         if (xfer) begin
            out_data_d = grant_data;
            out_sel_d  = grant_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule
